// File: rtl/wb_pkg.sv
// Shared widths and the buffered write-back entry type for the write-back arbiter.
package wb_pkg;

    localparam int REG_ADDR_W    = 5;
    localparam int REG_DATA_W    = 32;
    localparam int WB_FIFO_DEPTH = 2;
    localparam int CNT_W         = 2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic [REG_DATA_W-1:0] wdata;
    } wb_entry_t;

    // Register x0 is hardwired, so a write to it is consumed but never issued.
    function automatic logic addr_writes(input logic [REG_ADDR_W-1:0] waddr);
        return waddr != '0;
    endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry in-order FIFO of {waddr, wdata}; exposes every slot's address and
// occupancy so the arbiter can detect write-after-write hazards against loads.
module wb_fifo2
    import wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] push_waddr,
    input  logic [REG_DATA_W-1:0] push_wdata,
    input  logic                  pop,
    output logic [REG_ADDR_W-1:0] head_waddr,
    output logic [REG_DATA_W-1:0] head_wdata,
    output logic [CNT_W-1:0]      count,
    output logic [REG_ADDR_W-1:0] entry_waddr0,
    output logic [REG_ADDR_W-1:0] entry_waddr1,
    output logic [1:0]            entry_valid
);

    wb_entry_t        mem [WB_FIFO_DEPTH];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             pop_ok;
    logic             push_ok;
    wb_entry_t        push_entry;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign pop_ok  = pop && (cnt != '0);
    assign push_ok = push && ((cnt != CNT_W'(WB_FIFO_DEPTH)) || pop_ok);

    assign push_entry.waddr = push_waddr;
    assign push_entry.wdata = push_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy alone says what is live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head_waddr   = mem[rd_ptr].waddr;
    assign head_wdata   = mem[rd_ptr].wdata;
    assign count        = cnt;
    assign entry_waddr0 = mem[0].waddr;
    assign entry_waddr1 = mem[1].waddr;

    // The head slot is live with one entry; the other slot needs a full FIFO.
    assign entry_valid[0] = rd_ptr ? (cnt == CNT_W'(2)) : (cnt != '0);
    assign entry_valid[1] = rd_ptr ? (cnt != '0) : (cnt == CNT_W'(2));

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: loads win the write port, EX results are
// buffered in order in a two-entry FIFO, and loads wait out WAW hazards on it.
module wb_arbiter
    import wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid_i,
    input  logic [REG_ADDR_W-1:0] ex_waddr_i,
    input  logic [REG_DATA_W-1:0] ex_wdata_i,
    output logic                  ex_ready_o,
    input  logic                  ld_valid_i,
    input  logic [REG_ADDR_W-1:0] ld_waddr_i,
    input  logic [REG_DATA_W-1:0] ld_wdata_i,
    output logic                  ld_ready_o,
    output logic                  reg_wen_o,
    output logic [REG_ADDR_W-1:0] reg_waddr_o,
    output logic [REG_DATA_W-1:0] reg_wdata_o,
    output logic [CNT_W-1:0]      fifo_cnt_o
);

    logic                  fifo_push;
    logic                  fifo_pop;
    logic [REG_ADDR_W-1:0] head_waddr;
    logic [REG_DATA_W-1:0] head_wdata;
    logic [CNT_W-1:0]      fifo_cnt;
    logic [REG_ADDR_W-1:0] entry_waddr0;
    logic [REG_ADDR_W-1:0] entry_waddr1;
    logic [1:0]            entry_valid;
    logic                  ld_hazard;
    logic                  ld_acc;
    logic                  ex_acc;
    logic                  ex_bypass;
    logic                  sel_vld_p0;
    logic [REG_ADDR_W-1:0] sel_waddr_p0;
    logic [REG_DATA_W-1:0] sel_wdata_p0;
    logic                  sel_writes_p0;

    wb_fifo2 u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (fifo_push),
        .push_waddr   (ex_waddr_i),
        .push_wdata   (ex_wdata_i),
        .pop          (fifo_pop),
        .head_waddr   (head_waddr),
        .head_wdata   (head_wdata),
        .count        (fifo_cnt),
        .entry_waddr0 (entry_waddr0),
        .entry_waddr1 (entry_waddr1),
        .entry_valid  (entry_valid)
    );

    // EX readiness looks only at registered occupancy, never at this cycle's pop.
    assign ex_ready_o = (fifo_cnt < CNT_W'(WB_FIFO_DEPTH));

    assign ld_hazard = addr_writes(ld_waddr_i) &&
                       ((entry_valid[0] && (entry_waddr0 == ld_waddr_i)) ||
                        (entry_valid[1] && (entry_waddr1 == ld_waddr_i)));
    assign ld_ready_o = !ld_hazard;

    assign ld_acc = ld_valid_i && ld_ready_o && !rst;
    assign ex_acc = ex_valid_i && ex_ready_o && !rst;

    // Stage p0: pick the write-port source by priority load > FIFO head > EX bypass.
    always_comb begin
        sel_vld_p0   = 1'b0;
        sel_waddr_p0 = '0;
        sel_wdata_p0 = '0;
        fifo_pop     = 1'b0;
        ex_bypass    = 1'b0;
        if (ld_acc) begin
            sel_vld_p0   = 1'b1;
            sel_waddr_p0 = ld_waddr_i;
            sel_wdata_p0 = ld_wdata_i;
        end else if (!rst && (fifo_cnt != '0)) begin
            sel_vld_p0   = 1'b1;
            sel_waddr_p0 = head_waddr;
            sel_wdata_p0 = head_wdata;
            fifo_pop     = 1'b1;
        end else if (ex_acc) begin
            sel_vld_p0   = 1'b1;
            sel_waddr_p0 = ex_waddr_i;
            sel_wdata_p0 = ex_wdata_i;
            ex_bypass    = 1'b1;
        end
    end

    assign fifo_push     = ex_acc && !ex_bypass;
    assign sel_writes_p0 = sel_vld_p0 && addr_writes(sel_waddr_p0);

    // Stage p1: registered write port; address/data hold unless a real write issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_wen_o   <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= '0;
        end else begin
            reg_wen_o <= sel_writes_p0;
            if (sel_writes_p0) begin
                reg_waddr_o <= sel_waddr_p0;
                reg_wdata_o <= sel_wdata_p0;
            end
        end
    end

    assign fifo_cnt_o = fifo_cnt;

endmodule
